mux_sched: RTL

//  Clocked scheduler that sources the dual-rail select token (ctl_a/ctl_b) for the
//  two-input handshake mux and arbitrates which input is steered to the output.

---
 rtl/mux_sched_pkg.sv | 21 ++
 rtl/mux_sched_if.sv | 22 ++
 rtl/mux_sched_sync_ff.sv | 23 ++
 rtl/mux_sched.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mux_sched_pkg.sv
// Shared types and helpers for the mux select-token scheduler.
package mux_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SET,
    RTZ
  } sched_st_t;

  localparam int SYNC_MIN = 2;

  // A lone eligible port always wins; a tie goes to port 0 or alternates with last_sel.
  function automatic logic rr_pick(input logic elig0, input logic elig1,
                                   input logic last_sel, input logic fixed_prio);
    if (elig0 && elig1) begin
      return fixed_prio ? 1'b0 : ~last_sel;
    end
    return elig1 && !elig0;
  endfunction

endpackage

// File: rtl/mux_sched_if.sv
// Request/ack inputs and select-token outputs between the scheduler and its environment.
interface mux_sched_if;
  logic req0;
  logic req1;
  logic actl_i;
  logic tmo_clr;
  logic ctl_a;
  logic ctl_b;
  logic busy;
  logic last_sel;
  logic tmo;

  modport master (
    output req0, req1, actl_i, tmo_clr,
    input  ctl_a, ctl_b, busy, last_sel, tmo
  );

  modport slave (
    input  req0, req1, actl_i, tmo_clr,
    output ctl_a, ctl_b, busy, last_sel, tmo
  );
endinterface

// File: rtl/mux_sched_sync_ff.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset to 0.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/mux_sched.sv
// Clocked scheduler for the two-input handshake mux: arbitrates the requests and
// drives the dual-rail select token through a four-phase handshake on actl_i.
module mux_sched
  import mux_sched_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit FIXED_PRIO  = 1'b0,
  parameter int TMO_W       = 8
) (
  input logic        clk,
  input logic        rst,
  mux_sched_if.slave bus
);

  localparam int STAGES = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;
  localparam logic [TMO_W-1:0] WDOG_MAX = '1;

  logic s_req0;
  logic s_req1;
  logic s_ack;

  sync_ff #(.STAGES(STAGES)) u_sync_req0 (.clk(clk), .rst(rst), .d(bus.req0),   .q(s_req0));
  sync_ff #(.STAGES(STAGES)) u_sync_req1 (.clk(clk), .rst(rst), .d(bus.req1),   .q(s_req1));
  sync_ff #(.STAGES(STAGES)) u_sync_ack  (.clk(clk), .rst(rst), .d(bus.actl_i), .q(s_ack));

  sched_st_t        state;
  logic             armed0;
  logic             armed1;
  logic [TMO_W-1:0] wdog;
  logic             ctl_a_q;
  logic             ctl_b_q;
  logic             busy_q;
  logic             last_sel_q;
  logic             tmo_q;

  logic             elig0;
  logic             elig1;
  logic             grant;
  logic             hold_phase;
  logic [TMO_W-1:0] wdog_inc;
  logic             tmo_set;

  // A fresh timeout always sets tmo; once saturated it re-fires only after a clear.
  always_comb begin
    elig0      = s_req0 && armed0;
    elig1      = s_req1 && armed1;
    grant      = rr_pick(elig0, elig1, last_sel_q, FIXED_PRIO);
    hold_phase = ((state == SET) && !s_ack) || ((state == RTZ) && s_ack);
    wdog_inc   = (wdog == WDOG_MAX) ? wdog : wdog + 1'b1;
    tmo_set    = 1'b0;
    if (hold_phase) begin
      tmo_set = (wdog_inc == WDOG_MAX) && ((wdog != WDOG_MAX) || !tmo_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      armed0     <= 1'b1;
      armed1     <= 1'b1;
      wdog       <= '0;
      ctl_a_q    <= 1'b0;
      ctl_b_q    <= 1'b0;
      busy_q     <= 1'b0;
      last_sel_q <= 1'b1;
      tmo_q      <= 1'b0;
    end else begin
      if (tmo_set) begin
        tmo_q <= 1'b1;
      end else if (bus.tmo_clr) begin
        tmo_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          wdog <= '0;
          if (!s_req0) armed0 <= 1'b1;
          if (!s_req1) armed1 <= 1'b1;
          // A stale ack must return to zero before a new token is issued.
          if ((elig0 || elig1) && !s_ack) begin
            state      <= SET;
            busy_q     <= 1'b1;
            last_sel_q <= grant;
            ctl_a_q    <= ~grant;
            ctl_b_q    <= grant;
            if (grant) armed1 <= 1'b0;
            else       armed0 <= 1'b0;
          end
        end
        SET: begin
          if (!s_req0) armed0 <= 1'b1;
          if (!s_req1) armed1 <= 1'b1;
          if (s_ack) begin
            state   <= RTZ;
            ctl_a_q <= 1'b0;
            ctl_b_q <= 1'b0;
            wdog    <= '0;
          end else begin
            wdog <= wdog_inc;
          end
        end
        RTZ: begin
          if (!s_ack) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            wdog   <= '0;
          end else begin
            wdog <= wdog_inc;
          end
        end
        default: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          ctl_a_q <= 1'b0;
          ctl_b_q <= 1'b0;
          wdog    <= '0;
        end
      endcase
    end
  end

  assign bus.ctl_a    = ctl_a_q;
  assign bus.ctl_b    = ctl_b_q;
  assign bus.busy     = busy_q;
  assign bus.last_sel = last_sel_q;
  assign bus.tmo      = tmo_q;

endmodule
